rvx_apb_initiator: RTL and testbench

RVX_APB_INITIATOR -- requirements
Module: rvx_apb_initiator

---
 rtl/rvx_apb_initiator.sv | 170 +++++++++++++++++
 tb/tb_rvx_apb_initiator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_apb_initiator.sv
// Single-outstanding APB initiator: request/response handshakes in, APB master out.
// Optional ACCESS-phase timeout is built only when RVX_APB_INITIATOR_TIMEOUT_EN is defined.
module rvx_apb_initiator #(
  parameter int BW_ADDR        = 12,
  parameter int BW_DATA        = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [BW_ADDR-1:0] req_addr,
  input  logic [BW_DATA-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BW_DATA-1:0] rsp_rdata,
  output logic               rsp_error,
  output logic               rsp_timeout,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [BW_ADDR-1:0] paddr,
  output logic [BW_DATA-1:0] pwdata,
  input  logic [BW_DATA-1:0] prdata,
  input  logic               pready,
  input  logic               pslverr
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cfg
    $error("rvx_apb_initiator: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [BW_ADDR-1:0]   paddr_q, paddr_d;
  logic [BW_DATA-1:0]   pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [BW_DATA-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_error_q, rsp_error_d;

`ifdef RVX_APB_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
`ifdef RVX_APB_INITIATOR_TIMEOUT_EN
    cnt_d         = '0;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d  = SETUP;
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef RVX_APB_INITIATOR_TIMEOUT_EN
        cnt_d = CNT_W'(1);
`endif
      end
      ACCESS: begin
        // pready wins over an expiring timeout in the same cycle
        if (pready) begin
          state_d     = RESP;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_error_d = pslverr;
`ifdef RVX_APB_INITIATOR_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d       = RESP;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decode them from the next state
    req_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

`ifdef RVX_APB_INITIATOR_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign req_ready = req_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_rvx_apb_initiator.sv
// Directed self-checking bench for rvx_apb_initiator (timeout cases follow RVX_APB_INITIATOR_TIMEOUT_EN).
module tb_rvx_apb_initiator;

  logic        clk;
  logic        rstnn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  rvx_apb_initiator #(
    .BW_ADDR       (12),
    .BW_DATA       (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rstnn      (rstnn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one edge; DUT is in SETUP afterwards
  task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    rstnn     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    rstnn = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);

    // ---- write, zero wait states (pready held high, ignored outside ACCESS) ----
    pready = 1'b1;
    prdata = 32'hFFFF_FFFF;
    send(1'b1, 12'h010, 32'hA5A5_0001);
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_paddr", paddr, 12'h010);
    check("wr_setup_pwdata", pwdata, 32'hA5A5_0001);
    check("wr_setup_req_ready", req_ready, 0);
    check("wr_setup_rsp_valid", rsp_valid, 0);
    tick();
    check("wr_access_psel", psel, 1);
    check("wr_access_penable", penable, 1);
    check("wr_access_rsp_valid", rsp_valid, 0);
    tick();
    check("wr_resp_valid", rsp_valid, 1);
    check("wr_resp_psel", psel, 0);
    check("wr_resp_penable", penable, 0);
    check("wr_resp_error", rsp_error, 0);
    check("wr_resp_rdata", rsp_rdata, 0);
    check("wr_resp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_done_rsp_valid", rsp_valid, 0);
    check("wr_done_req_ready", req_ready, 1);

    // ---- read with 3 wait states ----
    pready = 1'b0;
    prdata = 32'hDEAD_BEEF;
    send(1'b0, 12'h0AC, 32'h0000_0000);
    check("rd_setup_pwrite", pwrite, 0);
    check("rd_setup_paddr", paddr, 12'h0AC);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rd_access_penable", penable, 1);
      check("rd_access_psel", psel, 1);
      check("rd_access_paddr", paddr, 12'h0AC);
      check("rd_access_rsp_valid", rsp_valid, 0);
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'h1234_5678;
      end
      tick();
    end
    pready = 1'b0;
    check("rd_resp_valid", rsp_valid, 1);
    check("rd_resp_rdata", rsp_rdata, 32'h1234_5678);
    check("rd_resp_error", rsp_error, 0);

    // ---- backpressure: response held, new requests and bus noise ignored ----
    req_valid = 1'b1;
    req_addr  = 12'h3FF;
    prdata    = 32'h5555_AAAA;
    pready    = 1'b1;
    pslverr   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
      check("bp_rsp_error", rsp_error, 0);
      check("bp_req_ready", req_ready, 0);
      check("bp_psel", psel, 0);
    end
    req_valid = 1'b0;
    req_addr  = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_done_rsp_valid", rsp_valid, 0);
    check("bp_done_req_ready", req_ready, 1);
    check("bp_done_psel", psel, 0);

    // ---- slave error ----
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hCAFE_0000;
    send(1'b0, 12'h004, 32'h0);
    tick();
    tick();
    pslverr = 1'b0;
    pready  = 1'b0;
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_error", rsp_error, 1);
    check("err_rsp_timeout", rsp_timeout, 0);
    check("err_rsp_rdata", rsp_rdata, 32'hCAFE_0000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

`ifdef RVX_APB_INITIATOR_TIMEOUT_EN
    // ---- timeout: pready stuck low for 8 ACCESS cycles ----
    prdata = 32'h7777_7777;
    send(1'b0, 12'h100, 32'h0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      check("to_access_penable", penable, 1);
      check("to_access_rsp_valid", rsp_valid, 0);
      tick();
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_error", rsp_error, 1);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_penable", penable, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- pready on the 8th ACCESS cycle completes normally ----
    prdata = 32'h0BAD_F00D;
    send(1'b0, 12'h104, 32'h0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      check("tp_access_penable", penable, 1);
      if (i == 8) pready = 1'b1;
      tick();
    end
    pready = 1'b0;
    check("tp_rsp_valid", rsp_valid, 1);
    check("tp_rsp_error", rsp_error, 0);
    check("tp_rsp_timeout", rsp_timeout, 0);
    check("tp_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`else
    // ---- no timeout logic: ACCESS waits well past TIMEOUT_CYCLES ----
    prdata = 32'h0BAD_F00D;
    send(1'b0, 12'h104, 32'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      check("nt_access_penable", penable, 1);
      check("nt_access_rsp_valid", rsp_valid, 0);
      check("nt_rsp_timeout", rsp_timeout, 0);
      tick();
    end
    pready = 1'b1;
    tick();
    pready = 1'b0;
    check("nt_rsp_valid", rsp_valid, 1);
    check("nt_rsp_error", rsp_error, 0);
    check("nt_rsp_timeout_resp", rsp_timeout, 0);
    check("nt_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    // ---- reset during ACCESS ----
    send(1'b1, 12'h020, 32'h1111_2222);
    tick();
    check("ra_penable_before", penable, 1);
    rstnn = 1'b0;
    #1;
    check("ra_psel_async", psel, 0);
    check("ra_penable_async", penable, 0);
    check("ra_paddr_async", paddr, 0);
    pready = 1'b1;
    tick();
    rstnn = 1'b1;
    check("ra_rsp_valid_in_rst", rsp_valid, 0);
    tick();
    check("ra_rsp_valid_after", rsp_valid, 0);
    check("ra_req_ready_after", req_ready, 1);
    check("ra_psel_after", psel, 0);
    tick();
    check("ra_rsp_valid_after2", rsp_valid, 0);

    prdata = 32'h4242_4242;
    send(1'b0, 12'h030, 32'h0);
    check("ra_new_psel", psel, 1);
    check("ra_new_paddr", paddr, 12'h030);
    tick();
    tick();
    pready = 1'b0;
    check("ra_new_rsp_valid", rsp_valid, 1);
    check("ra_new_rsp_rdata", rsp_rdata, 32'h4242_4242);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("ra_new_done", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
